// File: rtl/dm9000a_reader_pkg.sv
// Shared definitions for the DM9000A host read engine: register indices,
// bus-timing defaults, FSM state encoding and the registered bus-drive payload.
package dm9000a_reader_pkg;

  localparam logic [7:0] REG_NSR    = 8'h01;
  localparam logic [7:0] REG_MRCMDX = 8'hF0;
  localparam logic [7:0] REG_MRCMD  = 8'hF2;
  localparam logic [7:0] REG_ISR    = 8'hFE;

  localparam int unsigned DEF_SETUP_CYC = 1;
  localparam int unsigned DEF_PULSE_CYC = 2;
  localparam int unsigned DEF_HOLD_CYC  = 1;
  localparam int unsigned DEF_GAP_CYC   = 2;
  localparam int unsigned DEF_LEN_W     = 11;

  localparam int unsigned TMR_W  = 8;
  localparam int unsigned WORD_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_IX_SETUP = 4'd1,
    ST_IX_PULSE = 4'd2,
    ST_IX_HOLD  = 4'd3,
    ST_GAP      = 4'd4,
    ST_RD_SETUP = 4'd5,
    ST_RD_PULSE = 4'd6,
    ST_RD_HOLD  = 4'd7,
    ST_WAIT_OUT = 4'd8
  } dm9000a_rd_state_t;

  // Everything driven toward the ENET_* pins, registered as one word
  typedef struct packed {
    logic              cs_n;
    logic              cmd;
    logic              wr_n;
    logic              rd_n;
    logic              oe;
    logic [WORD_W-1:0] data;
  } enet_drive_t;

  localparam enet_drive_t DRV_IDLE = '{cs_n: 1'b1, cmd: 1'b0, wr_n: 1'b1,
                                       rd_n: 1'b1, oe: 1'b0, data: '0};

  // A phase of N cycles loads N-1 so done is seen on its last cycle
  function automatic logic [TMR_W-1:0] phase_load(input int unsigned cyc);
    return (cyc == 0) ? '0 : TMR_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/dm9000a_reader_if.sv
// Request and read-word stream between packet/register logic and the read engine.
interface dm9000a_reader_if #(
  parameter int unsigned LEN_W = 11
);
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_index;
  logic [LEN_W-1:0] req_len;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic             out_last;

  modport master (
    output req_valid, req_index, req_len, out_ready,
    input  req_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  req_valid, req_index, req_len, out_ready,
    output req_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/dm9000a_phase_timer.sv
// Loadable down-counter timing each bus phase; done_c is high once the count is 0.
module dm9000a_phase_timer
  import dm9000a_reader_pkg::*;
(
  input  logic             clk100,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             done_c
);

  logic [TMR_W-1:0] cnt_q;

  // Saturating count; never wraps below zero
  always_ff @(posedge clk100) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - TMR_W'(1);
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/dm9000a_reader.sv
// DM9000A read engine: one index-write cycle then 1..N data-read cycles,
// streaming each word out with valid/ready and a last flag.
module dm9000a_reader
  import dm9000a_reader_pkg::*;
#(
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
  parameter int unsigned GAP_CYC   = DEF_GAP_CYC,
  parameter int unsigned LEN_W     = DEF_LEN_W
) (
  input  logic                clk100,
  input  logic                rst,
  dm9000a_reader_if.slave     host,
  output logic                enet_cs_n,
  output logic                enet_cmd,
  output logic                enet_wr_n,
  output logic                enet_rd_n,
  output logic [WORD_W-1:0]   data_o,
  output logic                data_oe,
  input  logic [WORD_W-1:0]   data_i,
  input  logic                irq_i,
  output logic                irq_o
);

  localparam logic [3:0] IDLE     = 4'(ST_IDLE);
  localparam logic [3:0] IX_SETUP = 4'(ST_IX_SETUP);
  localparam logic [3:0] IX_PULSE = 4'(ST_IX_PULSE);
  localparam logic [3:0] IX_HOLD  = 4'(ST_IX_HOLD);
  localparam logic [3:0] GAP      = 4'(ST_GAP);
  localparam logic [3:0] RD_SETUP = 4'(ST_RD_SETUP);
  localparam logic [3:0] RD_PULSE = 4'(ST_RD_PULSE);
  localparam logic [3:0] RD_HOLD  = 4'(ST_RD_HOLD);
  localparam logic [3:0] WAIT_OUT = 4'(ST_WAIT_OUT);

  logic [3:0]        state_q, state_nxt;
  enet_drive_t       drv_q, drv_nxt;
  logic [7:0]        idx_q, idx_src_c;
  logic [LEN_W-1:0]  words_q;
  logic              req_ready_q, out_valid_q, out_last_q;
  logic [WORD_W-1:0] out_data_q;
  logic              irq_meta_q, irq_q;
  logic              tmr_load_c, tmr_done_c;
  logic [TMR_W-1:0]  tmr_val_c;
  logic              accept_c, consume_c, capture_c;

  function automatic int unsigned phase_cyc(input logic [3:0] st);
    case (st)
      IX_SETUP, RD_SETUP: phase_cyc = SETUP_CYC;
      IX_PULSE, RD_PULSE: phase_cyc = PULSE_CYC;
      IX_HOLD,  RD_HOLD:  phase_cyc = HOLD_CYC;
      GAP:                phase_cyc = GAP_CYC;
      default:            phase_cyc = 0;
    endcase
  endfunction

  assign accept_c  = (state_q == IDLE) && host.req_valid && req_ready_q;
  assign consume_c = out_valid_q && host.out_ready;
  assign capture_c = (state_q == RD_PULSE) && tmr_done_c;
  assign idx_src_c = (state_q == IDLE) ? host.req_index : idx_q;

  dm9000a_phase_timer u_timer (
    .clk100   (clk100),
    .rst      (rst),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .done_c   (tmr_done_c)
  );

  // Next state, phase-timer reload and next bus drive (decoded from next state)
  always_comb begin
    state_nxt  = state_q;
    drv_nxt    = DRV_IDLE;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;

    case (state_q)
      IDLE:     if (accept_c)   state_nxt = IX_SETUP;
      IX_SETUP: if (tmr_done_c) state_nxt = IX_PULSE;
      IX_PULSE: if (tmr_done_c) state_nxt = IX_HOLD;
      IX_HOLD:  if (tmr_done_c) state_nxt = GAP;
      GAP:      if (tmr_done_c) state_nxt = (words_q == '0) ? IDLE : RD_SETUP;
      RD_SETUP: if (tmr_done_c) state_nxt = RD_PULSE;
      RD_PULSE: if (tmr_done_c) state_nxt = RD_HOLD;
      RD_HOLD:  if (tmr_done_c) state_nxt = (out_valid_q && !host.out_ready) ? WAIT_OUT : GAP;
      WAIT_OUT: if (host.out_ready) state_nxt = GAP;
      default:  state_nxt = IDLE;
    endcase

    if (state_nxt != state_q) begin
      tmr_load_c = 1'b1;
      tmr_val_c  = phase_load(phase_cyc(state_nxt));
    end

    case (state_nxt)
      IX_SETUP, IX_PULSE, IX_HOLD: begin
        drv_nxt.cs_n = 1'b0;
        drv_nxt.oe   = 1'b1;
        drv_nxt.data = {8'h00, idx_src_c};
        drv_nxt.wr_n = (state_nxt != IX_PULSE);
      end
      RD_SETUP, RD_PULSE, RD_HOLD: begin
        drv_nxt.cs_n = 1'b0;
        drv_nxt.cmd  = 1'b1;
        drv_nxt.rd_n = (state_nxt != RD_PULSE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q     <= IDLE;
      drv_q       <= DRV_IDLE;
      req_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      words_q     <= '0;
      idx_q       <= '0;
      irq_meta_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      drv_q       <= drv_nxt;
      req_ready_q <= (state_nxt == IDLE);
      irq_meta_q  <= irq_i;
      irq_q       <= irq_meta_q;

      // A zero length is read as a single word
      if (accept_c) begin
        idx_q   <= host.req_index;
        words_q <= (host.req_len == '0) ? LEN_W'(1) : host.req_len;
      end else if (consume_c && words_q != '0) begin
        words_q <= words_q - LEN_W'(1);
      end

      if (capture_c) begin
        out_data_q  <= data_i;
        out_valid_q <= 1'b1;
        out_last_q  <= (words_q == LEN_W'(1));
      end else if (consume_c) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end
  end

  assign enet_cs_n      = drv_q.cs_n;
  assign enet_cmd       = drv_q.cmd;
  assign enet_wr_n      = drv_q.wr_n;
  assign enet_rd_n      = drv_q.rd_n;
  assign data_oe        = drv_q.oe;
  assign data_o         = drv_q.data;
  assign irq_o          = irq_q;
  assign host.req_ready = req_ready_q;
  assign host.out_valid = out_valid_q;
  assign host.out_data  = out_data_q;
  assign host.out_last  = out_last_q;

endmodule

// File: tb/tb_dm9000a_reader.sv
// Self-checking bench for dm9000a_reader: bus-side DM9000A model, protocol
// monitor, directed timing cases and randomized requests against a word-list model.
module tb_dm9000a_reader;
  import dm9000a_reader_pkg::*;

  localparam int unsigned SETUP = 1;
  localparam int unsigned PULSE = 2;
  localparam int unsigned HOLD  = 1;
  localparam int unsigned GAP   = 2;
  localparam int unsigned LW    = 11;
  localparam int unsigned FIRST_RD_LAT = 1 + SETUP + PULSE + HOLD + GAP + SETUP;
  localparam int unsigned WORD_SPACING = PULSE + HOLD + GAP + SETUP;

  logic        clk100 = 1'b0;
  logic        rst = 1'b1;
  logic        enet_cs_n, enet_cmd, enet_wr_n, enet_rd_n, data_oe;
  logic        irq_i, irq_o;
  logic [15:0] data_o, data_i;

  logic [15:0] bus_mem [0:63];
  int          base = 0;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  // Monitor-owned state
  int          rd_pulses = 0, wr_pulses = 0, viol = 0;
  int          last_wr_fall = 0, last_rd_fall = 0, prev_rd_fall = 0;
  logic [15:0] last_wr_data = '0;
  logic        prev_cs = 1'b1, prev_wr = 1'b1, prev_rd = 1'b1;
  int          cs_low_run = 0, cs_high_run = 1000, strobe_low_run = 0, hold_cnt = 0;

  always #5 clk100 = ~clk100;

  dm9000a_reader_if #(.LEN_W(LW)) bus_if ();

  dm9000a_reader #(
    .SETUP_CYC (SETUP),
    .PULSE_CYC (PULSE),
    .HOLD_CYC  (HOLD),
    .GAP_CYC   (GAP),
    .LEN_W     (LW)
  ) dut (
    .clk100    (clk100),
    .rst       (rst),
    .host      (bus_if),
    .enet_cs_n (enet_cs_n),
    .enet_cmd  (enet_cmd),
    .enet_wr_n (enet_wr_n),
    .enet_rd_n (enet_rd_n),
    .data_o    (data_o),
    .data_oe   (data_oe),
    .data_i    (data_i),
    .irq_i     (irq_i),
    .irq_o     (irq_o)
  );

  // DM9000A model: each read pulse returns the next word of the current request
  assign data_i = (!enet_rd_n) ? bus_mem[6'(rd_pulses - base)] : 16'hBAD0;

  always @(posedge clk100) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus protocol rules, sampled mid-cycle
  always @(negedge clk100) begin
    if (!rst) begin
      if (!enet_rd_n && (data_oe || bus_if.out_valid || enet_cmd !== 1'b1 || enet_cs_n)) viol++;
      if (!enet_wr_n && (!data_oe || enet_cmd !== 1'b0 || enet_cs_n)) viol++;
      if (!enet_wr_n && !enet_rd_n) viol++;
      if (data_oe && enet_cs_n) viol++;
      if (prev_wr && !enet_wr_n) begin
        wr_pulses++;
        last_wr_fall = cyc;
        last_wr_data = data_o;
        if (cs_low_run != SETUP) viol++;
      end
      if (prev_rd && !enet_rd_n) begin
        prev_rd_fall = last_rd_fall;
        last_rd_fall = cyc;
        if (cs_low_run != SETUP) viol++;
      end
      if ((!prev_wr && enet_wr_n) || (!prev_rd && enet_rd_n)) begin
        if (strobe_low_run != PULSE) viol++;
        hold_cnt = 0;
      end
      if (!prev_rd && enet_rd_n) rd_pulses++;
      if (prev_cs && !enet_cs_n && cs_high_run < GAP) viol++;
      if (!prev_cs && enet_cs_n && hold_cnt != HOLD) viol++;
    end
    cs_low_run     = enet_cs_n ? 0 : cs_low_run + 1;
    cs_high_run    = enet_cs_n ? cs_high_run + 1 : 0;
    strobe_low_run = (!enet_wr_n || !enet_rd_n) ? strobe_low_run + 1 : 0;
    if (!enet_cs_n && enet_wr_n && enet_rd_n) hold_cnt++;
    prev_cs = enet_cs_n;
    prev_wr = enet_wr_n;
    prev_rd = enet_rd_n;
  end

  // Issue a request; returns the cycle in which it was accepted, or -1
  task automatic issue(input logic [7:0] index, input logic [LW-1:0] len, output int acc_cyc);
    acc_cyc = -1;
    @(posedge clk100); #1;
    bus_if.req_valid = 1'b1;
    bus_if.req_index = index;
    bus_if.req_len   = len;
    for (int i = 0; i < 20 && acc_cyc < 0; i++) begin
      @(negedge clk100);
      if (bus_if.req_ready) acc_cyc = cyc;
    end
    if (acc_cyc < 0) check("req_accept", 32'd0, 32'd1);
    @(posedge clk100); #1;
    bus_if.req_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: random ready, 2: first word held off for 5 cycles
  task automatic run_txn(input logic [7:0] index, input logic [LW-1:0] len, input int mode,
                         input bit poke, input bit timing, input bit preset);
    int n, got, wr0, rd0, v0, acc_cyc, first_valid, bp_left, acc_word_cyc;
    n = (len == 0) ? 1 : int'(len);
    base = rd_pulses;
    if (!preset) for (int k = 0; k < n; k++) bus_mem[k] = 16'($urandom);
    wr0 = wr_pulses; rd0 = rd_pulses; v0 = viol;
    bus_if.out_ready = 1'b0;
    issue(index, len, acc_cyc);
    if (acc_cyc < 0) return;
    got = 0; first_valid = -1; bp_left = 5; acc_word_cyc = 0;
    for (int c = 0; c < 600 && got < n; c++) begin
      case (mode)
        0: bus_if.out_ready = 1'b1;
        1: bus_if.out_ready = 1'($urandom_range(0, 1));
        default: begin
          bus_if.out_ready = 1'b1;
          if (got == 0 && bus_if.out_valid && bp_left > 0) begin
            bus_if.out_ready = 1'b0;
            bp_left--;
          end
        end
      endcase
      bus_if.req_valid = poke && (cyc == acc_cyc + 3);
      bus_if.req_index = ~index;
      @(negedge clk100);
      if (bus_if.out_valid && first_valid < 0) first_valid = cyc;
      if (mode == 2 && got == 0 && bus_if.out_valid && !bus_if.out_ready &&
          cyc >= first_valid + int'(HOLD))
        check("bp_cs_n", 32'(enet_cs_n), 32'd1);
      if (bus_if.out_valid && bus_if.out_ready) begin
        check("out_data", 32'(bus_if.out_data), 32'(bus_mem[got]));
        check("out_last", 32'(bus_if.out_last), 32'(got == n - 1));
        if (got == 0) acc_word_cyc = cyc;
        got++;
      end
      @(posedge clk100); #1;
    end
    bus_if.req_valid = 1'b0;
    bus_if.out_ready = 1'b0;
    check("word_count", 32'(got), 32'(n));
    for (int i = 0; i < 30 && !bus_if.req_ready; i++) @(negedge clk100);
    check("ready_return", 32'(bus_if.req_ready), 32'd1);
    check("wr_pulses", 32'(wr_pulses - wr0), 32'd1);
    check("rd_pulses", 32'(rd_pulses - rd0), 32'(n));
    check("index_word", 32'(last_wr_data), {24'h0, index});
    check("bus_rules", 32'(viol - v0), 32'd0);
    if (timing) begin
      check("wr_fall_lat", 32'(last_wr_fall - acc_cyc), 32'(1 + SETUP));
      check("valid_lat", 32'(first_valid - acc_cyc), 32'(FIRST_RD_LAT + PULSE));
      if (n == 1) check("rd_fall_lat", 32'(last_rd_fall - acc_cyc), 32'(FIRST_RD_LAT));
      else        check("rd_spacing", 32'(last_rd_fall - prev_rd_fall), 32'(WORD_SPACING));
    end
    if (mode == 2 && n >= 2) begin
      check("bp_hold_cycles", 32'(acc_word_cyc - first_valid), 32'd5);
      check("bp_refall", 32'(last_rd_fall - acc_word_cyc >= int'(GAP + SETUP)), 32'd1);
    end
  endtask

  task automatic reset_mid_burst();
    int acc_cyc, lowcnt;
    base = rd_pulses;
    for (int k = 0; k < 3; k++) bus_mem[k] = 16'($urandom);
    bus_if.out_ready = 1'b1;
    issue(REG_MRCMD, LW'(3), acc_cyc);
    lowcnt = 0;
    for (int i = 0; i < 40 && lowcnt < int'(PULSE); i++) begin
      @(negedge clk100);
      if (!enet_rd_n) lowcnt++;
    end
    check("reach_rd_pulse", 32'(lowcnt), 32'(PULSE));
    rst = 1'b1;
    @(negedge clk100);
    check("rst_rd_n", 32'(enet_rd_n), 32'd1);
    check("rst_cs_n", 32'(enet_cs_n), 32'd1);
    check("rst_oe", 32'(data_oe), 32'd0);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk100);
    check("rst_ready_back", 32'(bus_if.req_ready), 32'd1);
    bus_if.out_ready = 1'b0;
  endtask

  task automatic irq_sync_test();
    logic hist [0:11];
    int highs;
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk100); #1;
      irq_i = (i >= 1 && i <= 3);
      hist[i] = irq_i;
      @(negedge clk100);
      if (i >= 2) check("irq_o", 32'(irq_o), 32'(hist[i-2]));
      if (irq_o) highs++;
    end
    check("irq_high_cycles", 32'(highs), 32'd3);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    irq_i = 1'b0;
    bus_if.req_valid = 1'b0;
    bus_if.req_index = '0;
    bus_if.req_len   = '0;
    bus_if.out_ready = 1'b0;
    for (int k = 0; k < 64; k++) bus_mem[k] = '0;

    repeat (3) @(posedge clk100);
    @(negedge clk100);
    check("reset_cs_n", 32'(enet_cs_n), 32'd1);
    check("reset_wr_n", 32'(enet_wr_n), 32'd1);
    check("reset_rd_n", 32'(enet_rd_n), 32'd1);
    check("reset_cmd", 32'(enet_cmd), 32'd0);
    check("reset_oe", 32'(data_oe), 32'd0);
    check("reset_data_o", 32'(data_o), 32'd0);
    check("reset_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("reset_out_last", 32'(bus_if.out_last), 32'd0);
    check("reset_out_data", 32'(bus_if.out_data), 32'd0);
    check("reset_irq_o", 32'(irq_o), 32'd0);
    check("reset_req_ready", 32'(bus_if.req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk100);
    check("ready_after_reset", 32'(bus_if.req_ready), 32'd1);

    irq_sync_test();

    bus_mem[0] = 16'h0083;
    run_txn(REG_ISR, LW'(1), 0, 1'b0, 1'b1, 1'b1);

    bus_mem[0] = 16'h1111; bus_mem[1] = 16'h2222; bus_mem[2] = 16'h3333;
    run_txn(REG_MRCMD, LW'(3), 0, 1'b0, 1'b1, 1'b1);

    run_txn(REG_MRCMD, LW'(2), 2, 1'b0, 1'b0, 1'b0);
    run_txn(REG_NSR, LW'(0), 0, 1'b1, 1'b1, 1'b0);

    reset_mid_burst();

    repeat (14) begin
      run_txn(8'($urandom), LW'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dm9000a_reader.md
Name: dm9000a_reader

Overview:
Host-side read engine for the DM9000A 16-bit processor bus; it is the read-direction counterpart of the existing write path. It accepts a register-index read request, runs one index-write cycle (CMD=0) and then 1..N data-read cycles (CMD=1). Each returned word is streamed out on a valid/ready interface with a last flag. The engine sits between packet/register logic and the top-level ENET_* pins; the tristate pad is external, so the data bus is split into data_o, data_oe and data_i.

Parameters:
SETUP_CYC, 1, clk100 cycles CS_N/CMD/index are stable before a WR_N or RD_N fall (≥10 ns)
PULSE_CYC, 2, clk100 cycles WR_N/RD_N are held low (≥10 ns)
HOLD_CYC, 1, clk100 cycles CS_N/CMD/data are held after a strobe rises (≥3 ns)
GAP_CYC, 2, clk100 cycles CS_N is high between consecutive bus cycles
LEN_W, 11, width of req_len (a 1536-byte frame is 768 words)

Ports:
clk100  in  1  100 MHz clock
rst  in  1  synchronous active-high reset
req_valid  in  1  read request valid
req_ready  out  1  engine idle and able to accept a request
req_index  in  8  DM9000A register index
req_len  in  LEN_W  number of 16-bit words to read; 0 is treated as 1
out_valid  out  1  read word available
out_ready  in  1  consumer accepts the word
out_data  out  16  read word
out_last  out  1  final word of the request
enet_cs_n  out  1  chip select, active low
enet_cmd  out  1  0 = index cycle, 1 = data cycle
enet_wr_n  out  1  write strobe, active low
enet_rd_n  out  1  read strobe, active low
data_o  out  16  bus drive value
data_oe  out  1  bus drive enable
data_i  in  16  bus sample value
irq_i  in  1  ENET_INT, asynchronous
irq_o  out  1  irq_i after a 2-flop synchronizer

Behaviour:
- Reset: one clock, synchronous and active-high (clk100, rst).
  - While rst is high at a clk100 edge: cs_n, wr_n and rd_n = 1; cmd, data_oe, data_o, out_valid, out_last, out_data and irq_o = 0; req_ready = 0; FSM goes to IDLE.
  - req_ready = 1 from the first cycle after rst deasserts.
- Request handshake:
  - A request is accepted when req_valid && req_ready. index and len are latched; req_ready drops the next cycle.
  - req_valid while busy is ignored; no queueing.
- FSM states: IDLE → IX_SETUP → IX_PULSE → IX_HOLD → GAP → RD_SETUP → RD_PULSE → RD_HOLD → (WAIT_OUT) → GAP → RD_SETUP ... → IDLE.
- Phase durations: SETUP, PULSE, HOLD and GAP states each last their parameter's cycle count, timed by a down-counter.
- Index cycle:
  - In IX_*: cs_n = 0, cmd = 0, data_oe = 1, data_o = {8'h00, index}.
  - wr_n = 0 only in IX_PULSE.
- Gaps: in GAP, cs_n = 1 and data_oe = 0. data_oe is never 1 during any RD_* state.
- Data cycle:
  - In RD_*: cs_n = 0, cmd = 1; rd_n = 0 only in RD_PULSE.
  - data_i is captured into out_data at the edge ending the last RD_PULSE cycle.
  - out_valid = 1 from the first RD_HOLD cycle until out_ready.
- Burst end and backpressure:
  - After RD_HOLD, if the word is unaccepted, the FSM waits in WAIT_OUT with cs_n = 1 and no strobes.
  - GAP starts only after acceptance. No further RD pulse occurs while out_valid = 1, so words are never lost or overwritten.
  - Word counter decrements on each acceptance. out_last = 1 when the remaining count is 1.
  - Acceptance of the last word → IDLE (via GAP, so consecutive requests also honour GAP_CYC); req_ready returns after GAP.
- Latency (defaults): accept at cycle 0 → IX_SETUP at cycle 1, wr_n low at cycles 2–3, GAP at 5–6, RD_SETUP at 7, rd_n low at 8–9, out_valid at cycle 10.
  - Burst word spacing with out_ready held high: 6 cycles.
- Reset mid-operation: all strobes, cs_n and data_oe return to their idle values at the same edge. out_valid clears and the burst is discarded.
- Counters saturate: never underflow below 0, and len wrap is impossible because len 0 maps to 1.

Decomposition:
- ProtocolInfo package:
  - DM9000A register indices: NSR 8'h01, MRCMDX 8'hF0, MRCMD 8'hF2, ISR 8'hFE.
  - Timing defaults.
  - FSM state enum typedef dm9000a_rd_state_t.
- Sub-module dm9000a_phase_timer: loadable down-counter providing done when the count reaches 0.

Test Plan:
- Single read of ISR (0xFE, len 1), bus model returns 16'h0083 → wr_n low at cycles 2–3 with data_o = 16'h00FE; rd_n low at 8–9; out_valid at cycle 10 with out_data = 16'h0083 and out_last = 1.
- MRCMD (0xF2) burst, len 3, model returns 16'h1111/16'h2222/16'h3333 → exactly one wr_n pulse and three rd_n pulses 6 cycles apart; out_last only on 16'h3333.
- Backpressure: out_ready low for 5 cycles on word 1 of a len-2 burst → rd_n stays 1 and cs_n stays 1 throughout; the second rd_n pulse falls ≥ GAP_CYC+SETUP_CYC cycles after acceptance.
- req_len = 0 → exactly one word with out_last = 1. A req_valid pulse during the burst → ignored, no extra bus cycle.
- rst asserted in the second RD_PULSE cycle → at the next edge rd_n = 1, cs_n = 1, data_oe = 0, out_valid = 0; req_ready = 1 one cycle after rst falls.
- irq_i pulses high for 3 cycles → irq_o follows, delayed by 2 cycles, for 3 cycles.
